fb_port_arbiter: RTL

//  Owns Port A of the VGA frame buffer. Shares it between two requesters:
//   - the CPU bus: single read/write accesses;
//   - an internal fill engine: clears or fills the whole buffer with one value.

---
 rtl/fb_port_arbiter_if.sv | 32 +++
 rtl/fb_port_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/fb_port_arbiter_if.sv
// Port A sharing bus: CPU access channel, fill control and frame buffer Port A pins.
// slave = arbiter side, master = CPU / fill controller / frame buffer side.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              CPU_REQ;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic              CPU_ACK;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              CPU_RVALID;
    logic              FILL_START;
    logic [DATA_W-1:0] FILL_VALUE;
    logic              FILL_BUSY;
    logic              FILL_DONE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [DATA_W-1:0] FB_WDATA;
    logic              FB_WE;
    logic [DATA_W-1:0] FB_RDATA;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, FILL_START, FILL_VALUE, FB_RDATA,
        output CPU_ACK, CPU_RDATA, CPU_RVALID, FILL_BUSY, FILL_DONE, FB_ADDR, FB_WDATA, FB_WE
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, FILL_START, FILL_VALUE, FB_RDATA,
        input  CPU_ACK, CPU_RDATA, CPU_RVALID, FILL_BUSY, FILL_DONE, FB_ADDR, FB_WDATA, FB_WE
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Frame buffer Port A arbiter: CPU single accesses share the port with a
// whole-buffer fill engine; the CPU wins except when the fill has starved too long.
module fb_port_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 32768,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    fb_port_arbiter_if.slave     bus
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [DATA_W-1:0] r_fill_val;
    logic [SC_W-1:0]   r_stall_cnt;
    logic              r_rvalid;

    logic w_fill_req, w_force, w_grant_cpu, w_grant_fill, w_last;

    // Grants are masked during RESET so an aborted fill leaves no stray write.
    assign w_fill_req   = (r_state == S_FILL);
    assign w_force      = w_fill_req && (r_stall_cnt == SC_W'(STARVE_LIMIT));
    assign w_grant_cpu  = bus.CPU_REQ && !w_force && !RESET;
    assign w_grant_fill = w_fill_req && !w_grant_cpu && !RESET;
    assign w_last       = (r_fill_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.CPU_ACK   = 1'b0;
        bus.FB_WE     = 1'b0;
        bus.FB_ADDR   = '0;
        bus.FB_WDATA  = '0;
        bus.FILL_BUSY = (r_state == S_FILL);
        bus.FILL_DONE = (r_state == S_DONE);
        bus.CPU_RVALID = r_rvalid;
        bus.CPU_RDATA  = r_rvalid ? bus.FB_RDATA : '0;

        case (r_state)
            S_IDLE:  if (bus.FILL_START) w_state_nxt = S_FILL;
            S_FILL:  if (w_grant_fill && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_grant_cpu) begin
            bus.CPU_ACK  = 1'b1;
            bus.FB_WE    = bus.CPU_WE;
            bus.FB_ADDR  = bus.CPU_ADDR;
            bus.FB_WDATA = bus.CPU_WDATA;
        end else if (w_grant_fill) begin
            bus.FB_WE    = 1'b1;
            bus.FB_ADDR  = r_fill_cnt;
            bus.FB_WDATA = r_fill_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fill_cnt  <= '0;
            r_fill_val  <= '0;
            r_stall_cnt <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.FILL_START) begin
                r_fill_val <= bus.FILL_VALUE;
                r_fill_cnt <= '0;
            end else if (w_grant_fill) begin
                r_fill_cnt <= w_last ? '0 : r_fill_cnt + ADDR_W'(1);
            end

            if (w_grant_fill || !w_fill_req) r_stall_cnt <= '0;
            else if (w_grant_cpu)            r_stall_cnt <= r_stall_cnt + SC_W'(1);

            r_rvalid <= w_grant_cpu && !bus.CPU_WE;
        end
    end
endmodule
